// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings, slave indices and default-slave state type.
// Optional feature macro used by dependants: AHB_MUX_ERRCNT_EN.
`default_nettype none

package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int SLV_P0  = 0;
  localparam int SLV_P1  = 1;
  localparam int SLV_P2  = 2;
  localparam int SLV_P3  = 3;
  localparam int SLV_P4  = 4;
  localparam int SLV_DEF = 5;
  localparam int SLV_NUM = 6;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

endpackage

`default_nettype wire

// File: rtl/ahblite_default_slave.sv
// ahblite_default_slave: two-cycle AHB ERROR responder for unmapped active transfers.
// Optional error counter / address capture when AHB_MUX_ERRCNT_EN is defined.
`default_nettype none

module ahblite_default_slave
  import ahb_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        hready_i,
  input  logic        dsel_i,
`ifdef AHB_MUX_ERRCNT_EN
  input  logic [31:0] haddr_i,
  output logic [15:0] err_cnt_o,
  output logic [31:0] err_addr_o,
`endif
  output logic        hreadyout_o,
  output logic        hresp_o
);

  ds_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_IDLE: if (hready_i && dsel_i) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = (hready_i && dsel_i) ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= DS_IDLE;
    else         state_q <= state_d;
  end

  // ERR1 is the wait cycle of the error response, ERR2 completes it
  assign hreadyout_o = (state_q != DS_ERR1);
  assign hresp_o     = (state_q == DS_IDLE) ? HRESP_OKAY : HRESP_ERROR;

`ifdef AHB_MUX_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic        err_entry_w;

  assign err_entry_w = (state_d == DS_ERR1);

  always_comb begin
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    if (err_entry_w) begin
      err_addr_d = haddr_i;
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err_cnt_o  = err_cnt_q;
  assign err_addr_o = err_addr_q;
`endif

endmodule

`default_nettype wire

// File: rtl/ahblite_slave_mux.sv
// ahblite_slave_mux: AHB-Lite response mux for five slaves plus a built-in default slave.
// Optional AHB_MUX_ERRCNT_EN adds HADDR input and ERR_CNT / ERR_ADDR outputs.
`default_nettype none

module ahblite_slave_mux
  import ahb_pkg::*;
#(
  parameter bit Port0_en = 1'b1,
  parameter bit Port1_en = 1'b1,
  parameter bit Port2_en = 1'b1,
  parameter bit Port3_en = 1'b1,
  parameter bit Port4_en = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [1:0]  HTRANS,
`ifdef AHB_MUX_ERRCNT_EN
  input  logic [31:0] HADDR,
  output logic [15:0] ERR_CNT,
  output logic [31:0] ERR_ADDR,
`endif
  input  logic        P0_HSEL,
  input  logic        P0_HREADYOUT,
  input  logic        P0_HRESP,
  input  logic [31:0] P0_HRDATA,
  input  logic        P1_HSEL,
  input  logic        P1_HREADYOUT,
  input  logic        P1_HRESP,
  input  logic [31:0] P1_HRDATA,
  input  logic        P2_HSEL,
  input  logic        P2_HREADYOUT,
  input  logic        P2_HRESP,
  input  logic [31:0] P2_HRDATA,
  input  logic        P3_HSEL,
  input  logic        P3_HREADYOUT,
  input  logic        P3_HRESP,
  input  logic [31:0] P3_HRDATA,
  input  logic        P4_HSEL,
  input  logic        P4_HREADYOUT,
  input  logic        P4_HRESP,
  input  logic [31:0] P4_HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  logic [4:0]         en_w, hsel_w, ep_w, pick_w, hreadyout_w, hresp_w;
  logic [31:0]        hrdata_w [5];
  logic               dsel_w;
  logic [SLV_NUM-1:0] sel_q, sel_d;
  logic               ds_hreadyout_w, ds_hresp_w;
  logic               unused_w;

  assign en_w        = {Port4_en, Port3_en, Port2_en, Port1_en, Port0_en};
  assign hsel_w      = {P4_HSEL, P3_HSEL, P2_HSEL, P1_HSEL, P0_HSEL};
  assign hreadyout_w = {P4_HREADYOUT, P3_HREADYOUT, P2_HREADYOUT, P1_HREADYOUT, P0_HREADYOUT};
  assign hresp_w     = {P4_HRESP, P3_HRESP, P2_HRESP, P1_HRESP, P0_HRESP};
  assign hrdata_w[0] = P0_HRDATA;
  assign hrdata_w[1] = P1_HRDATA;
  assign hrdata_w[2] = P2_HRDATA;
  assign hrdata_w[3] = P3_HRDATA;
  assign hrdata_w[4] = P4_HRDATA;
  assign unused_w    = HTRANS[0];

  assign ep_w   = hsel_w & en_w;
  // Isolate the lowest set bit so the lowest-numbered slave wins
  assign pick_w = ep_w & (~ep_w + 5'd1);
  assign dsel_w = ~|ep_w & HTRANS[1];

  assign sel_d = HREADY ? {dsel_w, pick_w} : sel_q;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) sel_q <= '0;
    else          sel_q <= sel_d;
  end

  always_comb begin
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    HRDATA = '0;
    for (int i = 0; i < 5; i++) begin
      if (sel_q[i]) begin
        HREADY = hreadyout_w[i];
        HRESP  = hresp_w[i];
        HRDATA = hrdata_w[i];
      end
    end
    if (sel_q[SLV_DEF]) begin
      HREADY = ds_hreadyout_w;
      HRESP  = ds_hresp_w;
    end
  end

  ahblite_default_slave u_default_slave (
    .clk_i       (HCLK),
    .rst_ni      (HRESETn),
    .hready_i    (HREADY),
    .dsel_i      (dsel_w),
`ifdef AHB_MUX_ERRCNT_EN
    .haddr_i     (HADDR),
    .err_cnt_o   (ERR_CNT),
    .err_addr_o  (ERR_ADDR),
`endif
    .hreadyout_o (ds_hreadyout_w),
    .hresp_o     (ds_hresp_w)
  );

endmodule

`default_nettype wire

// File: tb/tb_ahblite_slave_mux.sv
// tb_ahblite_slave_mux: directed checks of the AHB-Lite slave mux and default slave.
// Instance u_dut_a uses all ports enabled; u_dut_b disables port 3.
`default_nettype none

module tb_ahblite_slave_mux;
  import ahb_pkg::*;

  logic        HCLK;
  logic        HRESETn;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic        p_hsel  [5];
  logic        p_hrdy  [5];
  logic        p_hresp [5];
  logic [31:0] p_hrdata[5];

  logic        hready_a, hresp_a, hready_b, hresp_b;
  logic [31:0] hrdata_a, hrdata_b;
`ifdef AHB_MUX_ERRCNT_EN
  logic [15:0] err_cnt_a, err_cnt_b;
  logic [31:0] err_addr_a, err_addr_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  ahblite_slave_mux u_dut_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .HTRANS(HTRANS),
`ifdef AHB_MUX_ERRCNT_EN
    .HADDR(HADDR), .ERR_CNT(err_cnt_a), .ERR_ADDR(err_addr_a),
`endif
    .P0_HSEL(p_hsel[0]), .P0_HREADYOUT(p_hrdy[0]), .P0_HRESP(p_hresp[0]), .P0_HRDATA(p_hrdata[0]),
    .P1_HSEL(p_hsel[1]), .P1_HREADYOUT(p_hrdy[1]), .P1_HRESP(p_hresp[1]), .P1_HRDATA(p_hrdata[1]),
    .P2_HSEL(p_hsel[2]), .P2_HREADYOUT(p_hrdy[2]), .P2_HRESP(p_hresp[2]), .P2_HRDATA(p_hrdata[2]),
    .P3_HSEL(p_hsel[3]), .P3_HREADYOUT(p_hrdy[3]), .P3_HRESP(p_hresp[3]), .P3_HRDATA(p_hrdata[3]),
    .P4_HSEL(p_hsel[4]), .P4_HREADYOUT(p_hrdy[4]), .P4_HRESP(p_hresp[4]), .P4_HRDATA(p_hrdata[4]),
    .HREADY(hready_a), .HRESP(hresp_a), .HRDATA(hrdata_a)
  );

  ahblite_slave_mux #(.Port3_en(1'b0)) u_dut_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .HTRANS(HTRANS),
`ifdef AHB_MUX_ERRCNT_EN
    .HADDR(HADDR), .ERR_CNT(err_cnt_b), .ERR_ADDR(err_addr_b),
`endif
    .P0_HSEL(p_hsel[0]), .P0_HREADYOUT(p_hrdy[0]), .P0_HRESP(p_hresp[0]), .P0_HRDATA(p_hrdata[0]),
    .P1_HSEL(p_hsel[1]), .P1_HREADYOUT(p_hrdy[1]), .P1_HRESP(p_hresp[1]), .P1_HRDATA(p_hrdata[1]),
    .P2_HSEL(p_hsel[2]), .P2_HREADYOUT(p_hrdy[2]), .P2_HRESP(p_hresp[2]), .P2_HRDATA(p_hrdata[2]),
    .P3_HSEL(p_hsel[3]), .P3_HREADYOUT(p_hrdy[3]), .P3_HRESP(p_hresp[3]), .P3_HRDATA(p_hrdata[3]),
    .P4_HSEL(p_hsel[4]), .P4_HREADYOUT(p_hrdy[4]), .P4_HRESP(p_hresp[4]), .P4_HRDATA(p_hrdata[4]),
    .HREADY(hready_b), .HRESP(hresp_b), .HRDATA(hrdata_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Address phase returns to idle; every slave ready/OKAY with distinct data
  task automatic bus_idle();
    HTRANS = HTRANS_IDLE;
    HADDR  = 32'h0;
    for (int i = 0; i < 5; i++) begin
      p_hsel[i]   = 1'b0;
      p_hrdy[i]   = 1'b1;
      p_hresp[i]  = HRESP_OKAY;
      p_hrdata[i] = 32'hA0A0_0000 + 32'(i);
    end
  endtask

  task automatic chk_a(input string tag, input logic rdy, input logic rsp, input logic [31:0] dat);
    #1;
    check_eq({tag, "_hready"}, {31'd0, hready_a}, {31'd0, rdy});
    check_eq({tag, "_hresp"},  {31'd0, hresp_a},  {31'd0, rsp});
    check_eq({tag, "_hrdata"}, hrdata_a, dat);
  endtask

  task automatic chk_b(input string tag, input logic rdy, input logic rsp);
    #1;
    check_eq({tag, "_b_hready"}, {31'd0, hready_b}, {31'd0, rdy});
    check_eq({tag, "_b_hresp"},  {31'd0, hresp_b},  {31'd0, rsp});
  endtask

  initial begin
    bus_idle();
    HRESETn = 1'b0;
    repeat (3) tick();
    HRESETn = 1'b1;
    chk_a("reset", 1'b1, 1'b0, 32'h0);
    chk_b("reset", 1'b1, 1'b0);

    // RAMDATA read with two wait states
    p_hsel[1] = 1'b1; HTRANS = HTRANS_NONSEQ;
    tick();
    bus_idle(); p_hrdy[1] = 1'b0; p_hrdata[1] = 32'hDEADBEEF;
    chk_a("p1_wait1", 1'b0, 1'b0, 32'hDEADBEEF);
    tick();
    chk_a("p1_wait2", 1'b0, 1'b0, 32'hDEADBEEF);
    p_hrdy[1] = 1'b1;
    chk_a("p1_done", 1'b1, 1'b0, 32'hDEADBEEF);
    tick();
    chk_a("p1_after", 1'b1, 1'b0, 32'h0);

    // Unmapped NONSEQ: two-cycle ERROR, master drops to IDLE during ERR1
    HTRANS = HTRANS_NONSEQ; HADDR = 32'h6000_0004;
    tick();
    bus_idle();
    chk_a("unm_err1", 1'b0, 1'b1, 32'h0);
    tick();
    chk_a("unm_err2", 1'b1, 1'b1, 32'h0);
    tick();
    chk_a("unm_okay", 1'b1, 1'b0, 32'h0);
`ifdef AHB_MUX_ERRCNT_EN
    check_eq("errcnt_1", {16'd0, err_cnt_a}, 32'd1);
    check_eq("erraddr_1", err_addr_a, 32'h6000_0004);
`endif

    // Unmapped IDLE and BUSY: zero-wait OKAY
    HTRANS = HTRANS_IDLE;
    tick();
    chk_a("unm_idle", 1'b1, 1'b0, 32'h0);
    HTRANS = HTRANS_BUSY;
    tick();
    bus_idle();
    chk_a("unm_busy", 1'b1, 1'b0, 32'h0);

    // P3 access: served by P3 on u_dut_a, ERROR from u_dut_b (port disabled)
    p_hsel[3] = 1'b1; HTRANS = HTRANS_NONSEQ;
    tick();
    bus_idle(); p_hrdy[3] = 1'b0;
    chk_a("p3_stall", 1'b0, 1'b0, 32'hA0A0_0003);
    chk_b("p3dis_err1", 1'b0, 1'b1);
    tick();
    chk_b("p3dis_err2", 1'b1, 1'b1);
    p_hrdy[3] = 1'b1;
    chk_a("p3_done", 1'b1, 1'b0, 32'hA0A0_0003);
    tick();
    chk_b("p3dis_okay", 1'b1, 1'b0);

    // Two selects at once: lowest index (P0) wins over P2
    p_hsel[0] = 1'b1; p_hsel[2] = 1'b1; HTRANS = HTRANS_NONSEQ;
    tick();
    bus_idle();
    chk_a("prio_p0", 1'b1, 1'b0, 32'hA0A0_0000);
    tick();

    // Back-to-back unmapped accesses, then a P0 read
    HTRANS = HTRANS_NONSEQ; HADDR = 32'h7000_0010;
    tick();
    bus_idle();
    chk_a("b2b_err1a", 1'b0, 1'b1, 32'h0);
    tick();
    HTRANS = HTRANS_SEQ; HADDR = 32'h7000_0014;
    chk_a("b2b_err2a", 1'b1, 1'b1, 32'h0);
    tick();
    bus_idle();
    chk_a("b2b_err1b", 1'b0, 1'b1, 32'h0);
    tick();
    p_hsel[0] = 1'b1; HTRANS = HTRANS_NONSEQ;
    chk_a("b2b_err2b", 1'b1, 1'b1, 32'h0);
    tick();
    bus_idle(); p_hrdata[0] = 32'hC0FFEE00;
    chk_a("b2b_p0", 1'b1, 1'b0, 32'hC0FFEE00);
`ifdef AHB_MUX_ERRCNT_EN
    check_eq("errcnt_3", {16'd0, err_cnt_a}, 32'd3);
    check_eq("erraddr_3", err_addr_a, 32'h7000_0014);
`endif
    tick();

    // Reset during ERR1 aborts the error response
    HTRANS = HTRANS_NONSEQ;
    tick();
    bus_idle();
    chk_a("rst_err1", 1'b0, 1'b1, 32'h0);
    HRESETn = 1'b0;
    tick();
    HRESETn = 1'b1;
    chk_a("rst_err_after", 1'b1, 1'b0, 32'h0);
`ifdef AHB_MUX_ERRCNT_EN
    check_eq("errcnt_rst", {16'd0, err_cnt_a}, 32'd0);
`endif
    tick();
    chk_a("rst_err_idle", 1'b1, 1'b0, 32'h0);

    // Reset during a slave wait state: stall not honoured afterwards
    p_hsel[1] = 1'b1; HTRANS = HTRANS_NONSEQ;
    tick();
    bus_idle(); p_hrdy[1] = 1'b0;
    chk_a("rst_wait", 1'b0, 1'b0, 32'hA0A0_0001);
    HRESETn = 1'b0;
    tick();
    HRESETn = 1'b1;
    chk_a("rst_wait_after", 1'b1, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ahblite_slave_mux.md
Name: ahblite_slave_mux

Overview:
- Response-side counterpart of the AHB-Lite address decoder. It sits between the five decoded slaves (RAMCODE, RAMDATA, APB bridge, camera, LCD) and the Cortex-M0 master.
- Registers the one-hot slave select during the address phase. Multiplexes HRDATA/HREADYOUT/HRESP during the data phase.
- Contains a built-in default slave that returns a two-cycle AHB ERROR response for unmapped active transfers.

Parameters:
- Port0_en, 1, RAMCODE port enable; 0 forces P0_HSEL to be ignored, so the access goes to the default slave.
- Port1_en, 1, RAMDATA port enable.
- Port2_en, 1, APB bridge port enable.
- Port3_en, 1, camera port enable.
- Port4_en, 1, LCD port enable.

Ports:
- HCLK  input  1  system clock.
- HRESETn  input  1  synchronous active-low reset.
- HTRANS  input  2  master transfer type; bit 1 set means NONSEQ/SEQ.
- P0_HSEL..P4_HSEL  input  1 each  address-phase selects from the decoder.
- P0_HREADYOUT..P4_HREADYOUT  input  1 each  slave ready.
- P0_HRESP..P4_HRESP  input  1 each  slave response; 1 = ERROR.
- P0_HRDATA..P4_HRDATA  input  32 each  slave read data.
- HREADY  output  1  muxed ready, fed to the master and to every slave's HREADY input.
- HRESP  output  1  muxed response.
- HRDATA  output  32  muxed read data.

Behaviour:
- Effective select: eP[i] = Pi_HSEL & Port{i}_en.
- Default-slave select: dsel = ~|eP & HTRANS[1].
- If more than one eP is set, the lowest index wins.
- Data-phase select register sel_q (6 bits: P0..P4, DEF):
  - Loads {priority-encoded eP, dsel} on every rising HCLK where HREADY=1.
  - Holds while HREADY=0.
  - All-zero means "no slave": IDLE/BUSY to an unmapped address, or the state after reset.
- Output mux, combinational from sel_q:
  - Pi selected: HREADY=Pi_HREADYOUT, HRESP=Pi_HRESP, HRDATA=Pi_HRDATA.
  - DEF selected: HREADY/HRESP come from the default-slave FSM, HRDATA=0.
  - None selected: HREADY=1, HRESP=0, HRDATA=0.
- Default-slave FSM, states IDLE, ERR1, ERR2:
  - IDLE: drives HREADYOUT=1, HRESP=0. Moves to ERR1 when HREADY=1 and dsel=1.
  - ERR1: drives HREADYOUT=0, HRESP=1. Always moves to ERR2.
  - ERR2: drives HREADYOUT=1, HRESP=1. Moves to ERR1 if HREADY=1 and dsel=1 (back-to-back unmapped access), otherwise to IDLE.
- IDLE/BUSY transfers to unmapped space get a zero-wait OKAY and no FSM activity.
- The master may drop HTRANS to IDLE during ERR1. This is ignored because HREADY=0, so nothing is sampled.
- Latency: the mux adds 0 cycles. The error response is exactly 2 data-phase cycles.
- Reset (synchronous, HRESETn=0 at a rising edge):
  - sel_q=0 and FSM=IDLE.
  - Outputs therefore read HREADY=1, HRESP=0, HRDATA=0.
  - Reset asserted mid-wait-state or mid-ERR1 aborts the transfer the same way; the slave's own stall is not honoured after reset.

Optional Feature:
- Macro AHB_MUX_ERRCNT_EN.
- When defined, the block adds:
  - Input HADDR [31:0].
  - Output ERR_CNT [15:0]: increments on each ERR1 entry and saturates at 16'hFFFF.
  - Output ERR_ADDR [31:0]: HADDR captured on the same cycle.
  - Both outputs reset to 0.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS encodings: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - HRESP encodings: OKAY=0, ERROR=1.
  - Slave index constants 0..5, with DEF=5.
  - Default-slave state enum.
- One natural sub-module, ahblite_default_slave, containing the FSM (and the error counter when AHB_MUX_ERRCNT_EN is defined).

Test Plan:
- Reset check: hold HRESETn=0 for 3 cycles, release -> HREADY=1, HRESP=0, HRDATA=0; the first access then decodes normally.
- RAMDATA read: P1_HSEL=1, HTRANS=NONSEQ; next cycle P1_HRDATA=32'hDEADBEEF with P1_HREADYOUT low for 2 cycles -> HREADY low for 2 cycles, then HRDATA=32'hDEADBEEF with HREADY=1, HRESP=0.
- Unmapped NONSEQ: no HSEL, HTRANS=2'b10 -> data phase shows HREADY=0/HRESP=1, then HREADY=1/HRESP=1, then OKAY. With AHB_MUX_ERRCNT_EN, HADDR=32'h6000_0004 gives ERR_CNT=1 and ERR_ADDR=32'h6000_0004.
- Unmapped IDLE vs. disabled port:
  - No HSEL, HTRANS=IDLE -> zero-wait OKAY.
  - Port3_en=0 with P3_HSEL=1, HTRANS=NONSEQ -> two-cycle ERROR.
- Back-to-back: an unmapped NONSEQ is issued in the ERR2 cycle -> ERR1, ERR2, ERR1, ERR2 with no OKAY gap. A P0 access following the error is then served correctly from P0_HRDATA.
- Reset mid-ERR1: HRESETn=0 sampled during ERR1 -> next cycle HREADY=1, HRESP=0, FSM=IDLE. A counter that reached 16'hFFFF stays saturated on further errors until reset.
